// File: rtl/key_event_gen_pkg.sv
// Shared types and helpers for the key event generator: FSM state encoding
// and the hold-counter width calculation.
package key_event_gen_pkg;

  typedef enum logic [1:0] {
    KEY_ST_IDLE  = 2'd0,
    KEY_ST_PRESS = 2'd1,
    KEY_ST_HELD  = 2'd2
  } key_st_e;

  // Counter must hold values up to the larger terminal count.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Key-event bus: tick strobe and key levels in, per-key event pulses and held level out.
interface key_event_gen_if #(
  parameter int unsigned w = 4
);
  import key_event_gen_pkg::*;

  logic         en;
  logic [w-1:0] key;
  logic [w-1:0] press;
  logic [w-1:0] release_ev;
  logic [w-1:0] long_press;
  logic [w-1:0] repeat_ev;
  logic [w-1:0] held;

  modport master (
    output en, key,
    input  press, release_ev, long_press, repeat_ev, held
  );

  modport slave (
    input  en, key,
    output press, release_ev, long_press, repeat_ev, held
  );

endinterface

// File: rtl/key_event_fsm.sv
// One key: edge detection, press/hold FSM with en-tick hold counter, and
// registered one-clock event pulses plus the held level.
module key_event_fsm
  import key_event_gen_pkg::*;
#(
  parameter int unsigned long_ticks   = 8,
  parameter int unsigned repeat_ticks = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic key,
  output logic press,
  output logic release_ev,
  output logic long_press,
  output logic repeat_ev,
  output logic held
);

  localparam int unsigned CW = cnt_width(long_ticks, repeat_ticks);
  localparam logic [CW-1:0] LONG_TC = CW'(long_ticks - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(repeat_ticks - 1);

  key_st_e       state;
  logic [CW-1:0] cnt;
  logic          key_r;
  logic          rise;
  logic          fall;

  assign rise = key & ~key_r;
  assign fall = ~key & key_r;

  // key_r tracks key even in reset so a key held across reset yields no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_r      <= key;
      state      <= KEY_ST_IDLE;
      cnt        <= '0;
      press      <= 1'b0;
      release_ev <= 1'b0;
      long_press <= 1'b0;
      repeat_ev  <= 1'b0;
      held       <= 1'b0;
    end else begin
      key_r      <= key;
      press      <= 1'b0;
      release_ev <= 1'b0;
      long_press <= 1'b0;
      repeat_ev  <= 1'b0;
      case (state)
        KEY_ST_IDLE: begin
          if (rise) begin
            state <= KEY_ST_PRESS;
            cnt   <= '0;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end
        KEY_ST_PRESS: begin
          // Fall takes priority over a terminal tick in the same cycle.
          if (fall) begin
            state      <= KEY_ST_IDLE;
            cnt        <= '0;
            release_ev <= 1'b1;
            held       <= 1'b0;
          end else if (en) begin
            if (cnt == LONG_TC) begin
              state      <= KEY_ST_HELD;
              cnt        <= '0;
              long_press <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        KEY_ST_HELD: begin
          if (fall) begin
            state      <= KEY_ST_IDLE;
            cnt        <= '0;
            release_ev <= 1'b1;
            held       <= 1'b0;
          end else if (en) begin
            if (cnt == REP_TC) begin
              cnt       <= '0;
              repeat_ev <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= KEY_ST_IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Per-key event generator: fans en/key out to w independent key FSMs and
// packs their pulses back onto the bus.
module key_event_gen
  import key_event_gen_pkg::*;
#(
  parameter int unsigned w            = 4,
  parameter int unsigned long_ticks   = 8,
  parameter int unsigned repeat_ticks = 4
) (
  input logic          clk,
  input logic          reset,
  key_event_gen_if.slave bus
);

  for (genvar i = 0; i < int'(w); i++) begin : g_key
    key_event_fsm #(
      .long_ticks  (long_ticks),
      .repeat_ticks(repeat_ticks)
    ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .en        (bus.en),
      .key       (bus.key[i]),
      .press     (bus.press[i]),
      .release_ev(bus.release_ev[i]),
      .long_press(bus.long_press[i]),
      .repeat_ev (bus.repeat_ev[i]),
      .held      (bus.held[i])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: event-level reference model checked every cycle,
// plus hand-computed counts and timing offsets per directed scenario.
module tb_key_event_gen;

  localparam int W = 4;
  localparam int L = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_event_gen_if #(.w(W)) bus ();

  key_event_gen #(.w(W), .long_ticks(L), .repeat_ticks(R)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a press is "tracked"; count en ticks since press.
  logic [W-1:0] m_prev, m_trk;
  int           m_ticks [W];
  logic [W-1:0] e_press = '0, e_rel = '0, e_long = '0, e_rep = '0, e_held = '0;

  always @(posedge clk) begin
    logic r, f;
    int   t;
    for (int i = 0; i < W; i++) begin
      if (reset) begin
        m_prev[i]  <= bus.key[i];
        m_trk[i]   <= 1'b0;
        m_ticks[i] <= 0;
        e_press[i] <= 1'b0; e_rel[i] <= 1'b0; e_long[i] <= 1'b0;
        e_rep[i]   <= 1'b0; e_held[i] <= 1'b0;
      end else begin
        r = bus.key[i] & ~m_prev[i];
        f = ~bus.key[i] & m_prev[i];
        m_prev[i]  <= bus.key[i];
        e_press[i] <= 1'b0; e_rel[i] <= 1'b0; e_long[i] <= 1'b0; e_rep[i] <= 1'b0;
        if (!m_trk[i]) begin
          e_held[i] <= r;
          if (r) begin
            m_trk[i]   <= 1'b1;
            m_ticks[i] <= 0;
            e_press[i] <= 1'b1;
          end
        end else if (f) begin
          m_trk[i]  <= 1'b0;
          e_rel[i]  <= 1'b1;
          e_held[i] <= 1'b0;
        end else begin
          e_held[i] <= 1'b1;
          if (bus.en) begin
            t = m_ticks[i] + 1;
            m_ticks[i] <= t;
            if (t == L) e_long[i] <= 1'b1;
            else if (t > L && ((t - L) % R) == 0) e_rep[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare and event recording.
  logic chk_on = 1'b0;
  int   ncyc = 0;
  int   p_cnt [W], r_cnt [W], l_cnt [W], rp_cnt [W], h_cnt [W];
  int   p_at [W], r_at [W], l_at [W], rp_first [W];

  always @(negedge clk) begin
    if (chk_on) begin
      ncyc++;
      n_tests += 5;
      if (bus.press !== e_press) begin
        n_fail++; $display("FAIL press cyc=%0d got=%b exp=%b", ncyc, bus.press, e_press);
      end
      if (bus.release_ev !== e_rel) begin
        n_fail++; $display("FAIL release cyc=%0d got=%b exp=%b", ncyc, bus.release_ev, e_rel);
      end
      if (bus.long_press !== e_long) begin
        n_fail++; $display("FAIL long_press cyc=%0d got=%b exp=%b", ncyc, bus.long_press, e_long);
      end
      if (bus.repeat_ev !== e_rep) begin
        n_fail++; $display("FAIL repeat cyc=%0d got=%b exp=%b", ncyc, bus.repeat_ev, e_rep);
      end
      if (bus.held !== e_held) begin
        n_fail++; $display("FAIL held cyc=%0d got=%b exp=%b", ncyc, bus.held, e_held);
      end
      for (int i = 0; i < W; i++) begin
        if (bus.press[i] === 1'b1)      begin p_cnt[i]++; p_at[i] = ncyc; end
        if (bus.release_ev[i] === 1'b1) begin r_cnt[i]++; r_at[i] = ncyc; end
        if (bus.long_press[i] === 1'b1) begin l_cnt[i]++; l_at[i] = ncyc; end
        if (bus.repeat_ev[i] === 1'b1)  begin
          if (rp_cnt[i] == 0) rp_first[i] = ncyc;
          rp_cnt[i]++;
        end
        if (bus.held[i] === 1'b1) h_cnt[i]++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < W; i++) begin
      p_cnt[i] = 0; r_cnt[i] = 0; l_cnt[i] = 0; rp_cnt[i] = 0; h_cnt[i] = 0;
      p_at[i] = 0; r_at[i] = 0; l_at[i] = 0; rp_first[i] = 0;
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  int   ph = 0;
  logic en_all = 1'b0;
  task automatic next();
    @(posedge clk);
    #1;
    bus.en = en_all | (ph == 3);
    ph = (ph + 1) % 4;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) next();
  endtask

  initial begin
    reset   = 1'b1;
    bus.key = '0;
    bus.en  = 1'b0;
    clr();
    idle(3);
    chk_on = 1'b1;
    chk("reset_held", int'(bus.held), 0);
    chk("reset_press", int'(bus.press), 0);
    reset = 1'b0;
    idle(3);

    // Tap on key 0.
    clr(); ph = 0;
    next(); bus.key[0] = 1'b1;
    idle(5);
    next(); bus.key[0] = 1'b0;
    idle(3);
    chk("tap_press_cnt", p_cnt[0], 1);
    chk("tap_rel_cnt", r_cnt[0], 1);
    chk("tap_long_cnt", l_cnt[0], 0);
    chk("tap_held_cycles", h_cnt[0], 6);
    chk("tap_rel_offset", r_at[0] - p_at[0], 6);

    // Long hold on key 1, en every 4th clock.
    clr(); ph = 0;
    next(); bus.key[1] = 1'b1;
    idle(39);
    next(); bus.key[1] = 1'b0;
    idle(3);
    chk("long_press_cnt", p_cnt[1], 1);
    chk("long_long_cnt", l_cnt[1], 1);
    chk("long_long_offset", l_at[1] - p_at[1], 15);
    chk("long_rep_cnt", rp_cnt[1], 3);
    chk("long_rep_first", rp_first[1] - p_at[1], 23);
    chk("long_rel_cnt", r_cnt[1], 1);
    chk("long_rel_offset", r_at[1] - p_at[1], 40);

    // Key 2 falls on the cycle of its 4th en.
    clr(); ph = 0;
    next(); bus.key[2] = 1'b1;
    idle(14);
    next(); bus.key[2] = 1'b0;
    chk("term_en_is_high", int'(bus.en), 1);
    idle(3);
    chk("term_long_cnt", l_cnt[2], 0);
    chk("term_rel_cnt", r_cnt[2], 1);

    // Key 3 held across reset, then a clean press.
    clr();
    next(); reset = 1'b1; bus.key[3] = 1'b1;
    idle(1);
    next(); reset = 1'b0;
    idle(3);
    next(); bus.key[3] = 1'b0;
    idle(1);
    next(); bus.key[3] = 1'b1;
    idle(1);
    next(); bus.key[3] = 1'b0;
    idle(3);
    chk("rst_key3_press_cnt", p_cnt[3], 1);
    chk("rst_key3_rel_cnt", r_cnt[3], 1);

    // Reset while key 1 is in HELD.
    clr(); en_all = 1'b1;
    next(); bus.key[1] = 1'b1;
    idle(7);
    chk("rstheld_held_before", int'(bus.held[1]), 1);
    next(); reset = 1'b1;
    next();
    chk("rstheld_held_after", int'(bus.held), 0);
    chk("rstheld_pulses_after", int'(bus.press | bus.release_ev | bus.long_press | bus.repeat_ev), 0);
    reset = 1'b0; bus.key[1] = 1'b0;
    idle(3);
    en_all = 1'b0;
    chk("rstheld_long_cnt", l_cnt[1], 1);
    chk("rstheld_rel_cnt", r_cnt[1], 0);

    // All keys together, staggered releases.
    clr(); ph = 0;
    next(); bus.key = 4'b1111;
    next();
    chk("conc_press_all", int'(bus.press), 15);
    bus.key[0] = 1'b0;
    next(); bus.key[2] = 1'b0;
    idle(1);
    next(); bus.key[1] = 1'b0;
    next(); bus.key[3] = 1'b0;
    idle(3);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("conc_rel_cnt%0d", i), r_cnt[i], 1);
      chk($sformatf("conc_press_cnt%0d", i), p_cnt[i], 1);
    end
    chk("conc_rel_order", r_at[1] - r_at[0], 3);

    // en held high: long 4 clocks after press, repeat every 2.
    clr(); en_all = 1'b1;
    next(); bus.key[1] = 1'b1;
    idle(11);
    next(); bus.key[1] = 1'b0;
    idle(3);
    en_all = 1'b0;
    chk("enhi_long_offset", l_at[1] - p_at[1], 4);
    chk("enhi_rep_first", rp_first[1] - p_at[1], 6);
    chk("enhi_rep_cnt", rp_cnt[1], 3);
    chk("enhi_rel_cnt", r_cnt[1], 1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
